// File: rtl/wb_stage_pkg.sv
// Shared types for the write-back stage: LSU op encoding, FSM states and the
// pipeline-wide scoreboard tag width.
package wb_stage_pkg;

    localparam int TAG_WIDTH = 3;

    typedef enum logic {
        LSU_OP_LD = 1'b0,
        LSU_OP_ST = 1'b1
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_instret.sv
// Free-running 64-bit retired-instruction counter; wraps silently on overflow.
module wb_instret_cnt (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc_en,
    output logic [63:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 64'd0;
        end else if (inc_en) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// RV32 write-back stage: waits for LSU responses, writes the register file,
// forwards the result, clears scoreboard dirty bits and reports LSU faults.
module wb_stage #(
    parameter int TAG_WIDTH   = wb_stage_pkg::TAG_WIDTH,
    parameter int LSU_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   inst_valid_wb,
    input  logic                   rd_wr_en_wb,
    input  logic [TAG_WIDTH-1:0]   rd_wr_tag_wb,
    input  logic [4:0]             rd_wr_addr_wb,
    input  logic [31:0]            rd_wr_data_wb,
    input  logic                   lsu_en_wb,
    input  wb_stage_pkg::lsu_op_e  lsu_op_wb,
    input  logic [31:0]            lsu_rdata_wb,
    input  logic                   lsu_valid_wb,
    input  logic                   lsu_err_wb,
    input  logic                   exc_taken_wb,
    input  logic [31:0]            pc_wb,
    input  logic                   flush_W,
    output logic                   ready_wb,
    output logic                   rf_wr_en,
    output logic [4:0]             rf_wr_addr,
    output logic [31:0]            rf_wr_data,
    output logic                   forward_wb_en,
    output logic [TAG_WIDTH-1:0]   forward_wb_tag,
    output logic [4:0]             forward_wb_addr,
    output logic [31:0]            forward_wb_wdata,
    output logic                   clr_dirty_wb_en,
    output logic [4:0]             clr_dirty_wb_addr,
    output logic                   lsu_exc_valid,
    output logic [31:0]            lsu_exc_pc,
    output logic                   lsu_exc_store,
    output logic                   lsu_exc_timeout,
    output logic [63:0]            instret
);

    import wb_stage_pkg::*;

    localparam int CNT_W = $clog2(LSU_TIMEOUT + 1);

    wb_state_e        state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             kill;
    logic             timeout_hit;
    logic             done;      // slot leaves WB this cycle, by any path
    logic             commit;    // slot retires architecturally
    logic             exc;
    logic             exc_to;
    logic [31:0]      result;

    assign kill        = flush_W | exc_taken_wb;
    assign timeout_hit = (cnt == CNT_W'(LSU_TIMEOUT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state != IDLE && state_next != IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        ready_wb   = 1'b1;
        done       = 1'b0;
        commit     = 1'b0;
        exc        = 1'b0;
        exc_to     = 1'b0;
        case (state)
            IDLE: begin
                if (inst_valid_wb) begin
                    if (!lsu_en_wb) begin
                        done   = 1'b1;
                        commit = ~kill;
                    end else if (lsu_valid_wb) begin
                        done   = 1'b1;
                        commit = ~kill & ~lsu_err_wb;
                        exc    = ~kill & lsu_err_wb;
                    end else begin
                        ready_wb   = 1'b0;
                        state_next = kill ? DRAIN : WAIT;
                    end
                end
            end
            WAIT: begin
                ready_wb = 1'b0;
                // A flush that coincides with the response has nothing left to drain.
                if (flush_W) begin
                    if (lsu_valid_wb) begin
                        done       = 1'b1;
                        ready_wb   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (lsu_valid_wb) begin
                    done       = 1'b1;
                    ready_wb   = 1'b1;
                    commit     = ~lsu_err_wb;
                    exc        = lsu_err_wb;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    done       = 1'b1;
                    ready_wb   = 1'b1;
                    exc        = 1'b1;
                    exc_to     = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                ready_wb = 1'b0;
                if (lsu_valid_wb || timeout_hit) begin
                    done       = 1'b1;
                    ready_wb   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result = (lsu_en_wb && lsu_op_wb == LSU_OP_LD) ? lsu_rdata_wb : rd_wr_data_wb;

    assign rf_wr_en   = commit & rd_wr_en_wb & (rd_wr_addr_wb != 5'd0);
    assign rf_wr_addr = rf_wr_en ? rd_wr_addr_wb : 5'd0;
    assign rf_wr_data = rf_wr_en ? result : 32'd0;

    assign forward_wb_en    = rf_wr_en;
    assign forward_wb_tag   = rf_wr_en ? rd_wr_tag_wb : '0;
    assign forward_wb_addr  = rf_wr_addr;
    assign forward_wb_wdata = rf_wr_data;

    // Any exit that skips the rf write must still release the dirty bit.
    assign clr_dirty_wb_en   = done & rd_wr_en_wb & ~rf_wr_en;
    assign clr_dirty_wb_addr = clr_dirty_wb_en ? rd_wr_addr_wb : 5'd0;

    assign lsu_exc_valid   = exc;
    assign lsu_exc_pc      = exc ? pc_wb : 32'd0;
    assign lsu_exc_store   = exc & (lsu_op_wb == LSU_OP_ST);
    assign lsu_exc_timeout = exc_to;

    wb_instret_cnt u_instret (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_en  (commit),
        .count   (instret)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected rf writes are queued when a slot is
// driven and checked by a negedge monitor; other outputs checked inline.
module tb_wb_stage;

    import wb_stage_pkg::*;

    localparam int TW = 3;
    localparam int TO = 255;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            inst_valid_wb, rd_wr_en_wb, lsu_en_wb, lsu_valid_wb, lsu_err_wb;
    logic            exc_taken_wb, flush_W;
    logic [TW-1:0]   rd_wr_tag_wb;
    logic [4:0]      rd_wr_addr_wb;
    logic [31:0]     rd_wr_data_wb, lsu_rdata_wb, pc_wb;
    lsu_op_e         lsu_op_wb;
    logic            ready_wb, rf_wr_en, forward_wb_en, clr_dirty_wb_en;
    logic [4:0]      rf_wr_addr, forward_wb_addr, clr_dirty_wb_addr;
    logic [31:0]     rf_wr_data, forward_wb_wdata, lsu_exc_pc;
    logic [TW-1:0]   forward_wb_tag;
    logic            lsu_exc_valid, lsu_exc_store, lsu_exc_timeout;
    logic [63:0]     instret;

    always #5 clk = ~clk;

    wb_stage #(.TAG_WIDTH(TW), .LSU_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .inst_valid_wb(inst_valid_wb), .rd_wr_en_wb(rd_wr_en_wb),
        .rd_wr_tag_wb(rd_wr_tag_wb), .rd_wr_addr_wb(rd_wr_addr_wb),
        .rd_wr_data_wb(rd_wr_data_wb), .lsu_en_wb(lsu_en_wb), .lsu_op_wb(lsu_op_wb),
        .lsu_rdata_wb(lsu_rdata_wb), .lsu_valid_wb(lsu_valid_wb), .lsu_err_wb(lsu_err_wb),
        .exc_taken_wb(exc_taken_wb), .pc_wb(pc_wb), .flush_W(flush_W),
        .ready_wb(ready_wb), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .forward_wb_en(forward_wb_en),
        .forward_wb_tag(forward_wb_tag), .forward_wb_addr(forward_wb_addr),
        .forward_wb_wdata(forward_wb_wdata), .clr_dirty_wb_en(clr_dirty_wb_en),
        .clr_dirty_wb_addr(clr_dirty_wb_addr), .lsu_exc_valid(lsu_exc_valid),
        .lsu_exc_pc(lsu_exc_pc), .lsu_exc_store(lsu_exc_store),
        .lsu_exc_timeout(lsu_exc_timeout), .instret(instret)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slot();
        inst_valid_wb = 1'b0; rd_wr_en_wb = 1'b0; rd_wr_tag_wb = '0;
        rd_wr_addr_wb = 5'd0; rd_wr_data_wb = 32'd0; lsu_en_wb = 1'b0;
        lsu_op_wb = LSU_OP_LD; lsu_rdata_wb = 32'd0; lsu_valid_wb = 1'b0;
        lsu_err_wb = 1'b0; exc_taken_wb = 1'b0; pc_wb = 32'd0; flush_W = 1'b0;
    endtask

    task automatic set_slot(input logic [4:0] rd, input logic [31:0] data, input logic wr,
                            input logic lsu, input lsu_op_e op, input logic [31:0] pc);
        idle_slot();
        inst_valid_wb = 1'b1; rd_wr_en_wb = wr; rd_wr_addr_wb = rd;
        rd_wr_tag_wb = rd[TW-1:0]; rd_wr_data_wb = data; lsu_en_wb = lsu;
        lsu_op_wb = op; pc_wb = pc;
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && rf_wr_en === 1'b1) begin
            check("rf_wr_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rf_wr_addr", rf_wr_addr, e.addr);
                check("rf_wr_data", rf_wr_data, e.data);
                check("fwd_en", forward_wb_en, 1);
                check("fwd_wdata", forward_wb_wdata, e.data);
                check("fwd_tag", forward_wb_tag, e.addr[TW-1:0]);
            end
        end
    end

    initial begin
        int early;
        reset_n = 1'b0;
        idle_slot();
        repeat (2) @(posedge clk);
        #4;
        check("rst_ready", ready_wb, 1);
        check("rst_rf_wr_en", rf_wr_en, 0);
        check("rst_instret", instret, 0);
        check("rst_exc", lsu_exc_valid, 0);
        tick();
        reset_n = 1'b1;

        // ALU write x5
        tick();
        set_slot(5'd5, 32'h1234, 1'b1, 1'b0, LSU_OP_ST, 32'h10);
        push_exp(5'd5, 32'h1234);
        #3;
        check("alu_ready", ready_wb, 1);
        check("alu_rf_wr_en", rf_wr_en, 1);
        check("alu_instret_before", instret, 0);
        tick();
        idle_slot();
        #3;
        check("alu_instret_after", instret, 1);
        check("alu_bubble_no_wr", rf_wr_en, 0);

        // Load whose response arrives with the slot
        tick();
        set_slot(5'd8, 32'h1111, 1'b1, 1'b1, LSU_OP_LD, 32'h14);
        lsu_valid_wb = 1'b1; lsu_rdata_wb = 32'hCAFEF00D;
        push_exp(5'd8, 32'hCAFEF00D);
        #3;
        check("ld_fast_ready", ready_wb, 1);
        tick();
        idle_slot();
        #3;
        check("ld_fast_instret", instret, 2);

        // Load with response 3 cycles later
        tick();
        set_slot(5'd7, 32'h2222, 1'b1, 1'b1, LSU_OP_LD, 32'h18);
        push_exp(5'd7, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            #3;
            check("ld_wait_ready", ready_wb, 0);
            check("ld_wait_no_wr", rf_wr_en, 0);
            tick();
        end
        lsu_valid_wb = 1'b1; lsu_rdata_wb = 32'hDEADBEEF;
        #3;
        check("ld_resp_ready", ready_wb, 1);
        check("ld_resp_fwd_en", forward_wb_en, 1);
        check("ld_resp_fwd_addr", forward_wb_addr, 7);
        tick();
        idle_slot();
        #3;
        check("ld_after_fwd_en", forward_wb_en, 0);
        check("ld_instret", instret, 3);

        // Pending load flushed, late response discarded
        tick();
        set_slot(5'd9, 32'h3333, 1'b1, 1'b1, LSU_OP_LD, 32'h1C);
        #3;
        check("dr_ready0", ready_wb, 0);
        tick();
        flush_W = 1'b1;
        #3;
        check("dr_flush_ready", ready_wb, 0);
        check("dr_flush_no_wr", rf_wr_en, 0);
        tick();
        flush_W = 1'b0;
        #3;
        check("dr_drain_ready", ready_wb, 0);
        tick();
        lsu_valid_wb = 1'b1; lsu_rdata_wb = 32'hBAD0BAD0;
        #3;
        check("dr_exit_no_wr", rf_wr_en, 0);
        check("dr_clr_dirty", clr_dirty_wb_en, 1);
        check("dr_clr_addr", clr_dirty_wb_addr, 9);
        check("dr_exit_ready", ready_wb, 1);
        tick();
        idle_slot();
        #3;
        check("dr_instret", instret, 3);
        check("dr_idle_ready", ready_wb, 1);

        // Store bus error at pc 0x80
        tick();
        set_slot(5'd0, 32'h0, 1'b0, 1'b1, LSU_OP_ST, 32'h80);
        lsu_valid_wb = 1'b1; lsu_err_wb = 1'b1;
        #3;
        check("st_err_valid", lsu_exc_valid, 1);
        check("st_err_pc", lsu_exc_pc, 32'h80);
        check("st_err_store", lsu_exc_store, 1);
        check("st_err_timeout", lsu_exc_timeout, 0);
        check("st_err_no_wr", rf_wr_en, 0);
        tick();
        idle_slot();
        #3;
        check("st_err_pulse_end", lsu_exc_valid, 0);
        check("st_err_instret", instret, 3);

        // Load bus error after one wait cycle
        tick();
        set_slot(5'd6, 32'h4444, 1'b1, 1'b1, LSU_OP_LD, 32'h44);
        #3;
        check("ld_err_wait", ready_wb, 0);
        tick();
        lsu_valid_wb = 1'b1; lsu_err_wb = 1'b1;
        #3;
        check("ld_err_valid", lsu_exc_valid, 1);
        check("ld_err_store", lsu_exc_store, 0);
        check("ld_err_timeout", lsu_exc_timeout, 0);
        check("ld_err_pc", lsu_exc_pc, 32'h44);
        check("ld_err_clr_dirty", clr_dirty_wb_en, 1);
        check("ld_err_no_wr", rf_wr_en, 0);
        tick();
        idle_slot();
        #3;
        check("ld_err_instret", instret, 3);

        // No response: timeout after LSU_TIMEOUT wait cycles
        tick();
        set_slot(5'd3, 32'h5555, 1'b1, 1'b1, LSU_OP_LD, 32'h100);
        #3;
        check("to_enter_ready", ready_wb, 0);
        early = 0;
        for (int i = 0; i < TO; i++) begin
            tick();
            #3;
            if (lsu_exc_valid !== 1'b0 || ready_wb !== 1'b0) early++;
        end
        check("to_no_early_exit", early, 0);
        tick();
        #3;
        check("to_exc_valid", lsu_exc_valid, 1);
        check("to_exc_timeout", lsu_exc_timeout, 1);
        check("to_exc_store", lsu_exc_store, 0);
        check("to_exc_pc", lsu_exc_pc, 32'h100);
        check("to_no_wr", rf_wr_en, 0);
        check("to_clr_dirty", clr_dirty_wb_en, 1);
        tick();
        idle_slot();
        #3;
        check("to_idle_ready", ready_wb, 1);
        check("to_exc_end", lsu_exc_valid, 0);
        check("to_instret", instret, 3);

        // Write to x0 retires but never writes
        tick();
        set_slot(5'd0, 32'hFFFF, 1'b1, 1'b0, LSU_OP_ST, 32'h104);
        #3;
        check("x0_no_wr", rf_wr_en, 0);
        check("x0_clr_dirty", clr_dirty_wb_en, 1);
        tick();
        idle_slot();
        #3;
        check("x0_instret", instret, 4);

        // Reset while a load waits
        tick();
        set_slot(5'd4, 32'h6666, 1'b1, 1'b1, LSU_OP_LD, 32'h108);
        #3;
        check("rw_ready0", ready_wb, 0);
        tick();
        #3;
        check("rw_wait_ready", ready_wb, 0);
        tick();
        reset_n = 1'b0;
        idle_slot();
        #3;
        check("rw_rst_ready", ready_wb, 1);
        check("rw_rst_instret", instret, 0);
        check("rw_rst_no_wr", rf_wr_en, 0);
        tick();
        reset_n = 1'b1;
        #3;
        check("rw_post_ready", ready_wb, 1);
        tick();
        set_slot(5'd10, 32'hA5A5, 1'b1, 1'b0, LSU_OP_ST, 32'h10C);
        push_exp(5'd10, 32'hA5A5);
        #3;
        check("rw_post_wr", rf_wr_en, 1);
        tick();
        idle_slot();
        #3;
        check("rw_post_instret", instret, 1);

        tick();
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
